vga_text_console: RTL
=====================

Name: vga_text_console

Overview:
- Upstream feeder for the VGA character-cell display: turns an ASCII byte stream with a valid/ready handshake into single-cycle character-cell write strobes (charWr, colours, code, X, Y).
- Keeps a cursor over the 64x24 visible grid of 10x20 cells.
- Interprets control codes, wraps lines, and clears rows or the whole screen by sweeping space writes.
- Sits between the CPU/peripheral bus (or a UART receiver) and the VGA block's charWr port.

Parameters:
- COLS, 64, visible columns; 1..64; charWrX is fixed at 6 bits.
- ROWS, 24, visible rows; 1..32; charWrY is fixed at 5 bits.

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- inValid  in  1  a byte is offered on inData.
- inData  in  8  ASCII byte.
- inReady  out  1  block can accept a byte this cycle.
- fgColor  in  24  foreground colour, sampled at byte acceptance.
- bgColor  in  24  background colour, sampled at byte acceptance.
- charWr  out  1  one-cycle cell write strobe.
- charWrFgColor  out  24  foreground colour of the cell being written.
- charWrBgColor  out  24  background colour of the cell being written.
- charWrCode  out  8  character code of the cell being written.
- charWrX  out  6  column of the cell being written.
- charWrY  out  5  row of the cell being written.
- cursorX  out  6  current cursor column.
- cursorY  out  5  current cursor row.
- busy  out  1  a clear sweep is in progress.

Behaviour:
- All outputs are registered.
- Reset values: charWr=0; charWr* buses=0; cursorX=0; cursorY=0; inReady=0; busy=1; state=CLR_ALL; sweep counter=0.
- Reset is asynchronous and takes effect mid-operation: any sweep or write is abandoned immediately, and the reset clear restarts from cell (0,0).
- Acceptance: a byte is accepted on a posedge with inValid&&inReady.
- Write latency: the resulting charWr pulse appears on the next edge (1 cycle).
- Throughput: 1 byte/cycle while in IDLE with no line advance.
- States:
  - CLR_ALL: writes code 0x20 to every cell, row-major: (0,0),(1,0)..(COLS-1,0),(0,1)..(COLS-1,ROWS-1). One cell per cycle, charWr=1 each cycle, COLS*ROWS cycles. Colours: both 0 after reset; both = latched bgColor after form feed. On the last cell, go to IDLE with cursor (0,0). inReady=0, busy=1 throughout.
  - IDLE: inReady=1, busy=0. Decodes each accepted byte per the rules below.
  - CLR_LINE: writes 0x20 to cells (0..COLS-1, cursorY), COLS cycles, both colours = latched bgColor, then returns to IDLE. inReady=0, busy=1.
- Printable byte (>=0x20, including >=0x80):
  - Written verbatim at (cursorX,cursorY) with the latched fg/bg; cursorX+1.
  - If cursorX was COLS-1, perform a line advance instead of the increment.
- 0x0A (LF): line advance, no write.
- 0x0D (CR): cursorX=0, no write.
- 0x08 (BS):
  - If cursorX>0: cursorX-1, and write 0x20 with the latched colours at the new position.
  - Else if cursorY>0: cursor=(COLS-1, cursorY-1), with the same space write.
  - At (0,0): no effect, no write.
- 0x0C (FF): latch bgColor, enter CLR_ALL; the cursor ends at (0,0).
- Other codes <0x20: accepted and ignored.
- Line advance:
  - cursorX=0; cursorY+1, wrapping ROWS-1 -> 0.
  - Latch bgColor, enter CLR_LINE on the new row.
  - The printable write that triggered the wrap still completes at its original cell in the cycle before the sweep starts.
- inReady drops on the edge after acceptance of any byte that leads to CLR_ALL or CLR_LINE, so no byte is accepted in the transition cycle.
- Colour inputs changing during a sweep have no effect.
- inValid while inReady=0: ignored. The producer must hold the byte.

Optional Feature:
- Macro: VGA_TEXT_CONSOLE_TAB_EN.
- Defined: 0x09 sets cursorX to the next multiple of 8, with no write. If the result is >=COLS, perform a line advance instead.
- Undefined: 0x09 is treated like other control codes (accepted, ignored).

Test Plan:
- Reset release, inValid=0 -> inReady=0 and charWr=1 for exactly 1536 consecutive cycles covering (0,0)..(63,23), code 0x20, colours 0. Then inReady=1, busy=0, cursor (0,0).
- Stream 'A','B' back-to-back with fg=0xFFFFFF, bg=0x0000FF -> consecutive charWr with 0x41@(0,0) then 0x42@(1,0). Cursor ends (2,0); inReady stays 1.
- Cursor (63,5), send 'Z' -> write 0x5A@(63,5), then 64 space writes on row 6 with the latched bg. Cursor (0,6); inReady low for 64+1 cycles.
- Cursor (10,23), send 0x0A -> no write at (10,23); row 0 cleared; cursor (0,0).
- Cursor (0,3), send 0x08 -> space written @(63,2), cursor (63,2). At (0,0), 0x08 -> no charWr, cursor unchanged.
- Assert reset mid-CLR_LINE, then send 0x0C after the clear with bg=0x00FF00 -> the sweep restarts at (0,0) with colour 0. FF then clears 1536 cells with 0x00FF00. With TAB_EN defined, 0x09 at cursorX=13 -> cursorX=16, no write.

Source files
------------

// File: rtl/vga_text_console.sv
// vga_text_console
//
// Turns a valid/ready ASCII byte stream into single-cycle character-cell
// write strobes for the VGA character-cell display. A cursor is kept over
// the COLS x ROWS visible grid. Control codes move the cursor. Line advances
// and form feeds clear the screen by sweeping space writes, one cell per cycle.
//
// Ports:
//   CLOCK_50        system clock, all logic on posedge
//   reset           asynchronous, active-high reset
//   inValid/inData  offered ASCII byte
//   inReady         byte accepted on a posedge where inValid && inReady
//   fgColor/bgColor colours sampled when a byte is accepted
//   charWr*         registered one-cycle cell write (strobe, colours, code, X, Y)
//   cursorX/Y       current cursor position
//   busy            a clear sweep is in progress
//
// Optional build macro:
//   VGA_TEXT_CONSOLE_TAB_EN  when defined, 0x09 advances the cursor to the
//                            next multiple of 8 (line advance if past the end).
//                            When undefined, 0x09 is ignored like other
//                            control codes.

module vga_text_console #(
  parameter int COLS = 64,
  parameter int ROWS = 24
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        inValid,
  input  logic [7:0]  inData,
  output logic        inReady,
  input  logic [23:0] fgColor,
  input  logic [23:0] bgColor,
  output logic        charWr,
  output logic [23:0] charWrFgColor,
  output logic [23:0] charWrBgColor,
  output logic [7:0]  charWrCode,
  output logic [5:0]  charWrX,
  output logic [4:0]  charWrY,
  output logic [5:0]  cursorX,
  output logic [4:0]  cursorY,
  output logic        busy
);

  localparam logic [1:0] ST_CLR_ALL  = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_CLR_LINE = 2'd2;

  localparam logic [5:0] LAST_X = 6'(COLS - 1);
  localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

  localparam logic [7:0] CODE_SPACE = 8'h20;
  localparam logic [7:0] CODE_BS    = 8'h08;
  localparam logic [7:0] CODE_TAB   = 8'h09;
  localparam logic [7:0] CODE_LF    = 8'h0A;
  localparam logic [7:0] CODE_FF    = 8'h0C;
  localparam logic [7:0] CODE_CR    = 8'h0D;

  logic [1:0]  state_q,     state_d;
  logic [5:0]  sweep_x_q,   sweep_x_d;
  logic [4:0]  sweep_y_q,   sweep_y_d;
  logic [5:0]  cursor_x_q,  cursor_x_d;
  logic [4:0]  cursor_y_q,  cursor_y_d;
  logic [23:0] clr_color_q, clr_color_d;
  logic        char_wr_q,   char_wr_d;
  logic [23:0] wr_fg_q,     wr_fg_d;
  logic [23:0] wr_bg_q,     wr_bg_d;
  logic [7:0]  wr_code_q,   wr_code_d;
  logic [5:0]  wr_x_q,      wr_x_d;
  logic [4:0]  wr_y_q,      wr_y_d;
  logic        in_ready_q,  in_ready_d;
  logic        busy_q,      busy_d;

  logic        accept;
  logic        line_adv;
  logic [4:0]  next_row;

`ifdef VGA_TEXT_CONSOLE_TAB_EN
  // One bit wider than the column so a tab stop past column 63 is visible.
  logic [6:0]  tab_x;
  assign tab_x = ({1'b0, cursor_x_q} | 7'd7) + 7'd1;
`endif

  assign accept   = inValid && in_ready_q;
  assign next_row = (cursor_y_q == LAST_Y) ? 5'd0 : cursor_y_q + 5'd1;

  // Next-state logic. inReady and busy are derived from the current state
  // rather than the next one, so inReady only rises on the edge after the
  // last sweep write and never overlaps a sweep cycle.
  always_comb begin
    state_d     = state_q;
    sweep_x_d   = sweep_x_q;
    sweep_y_d   = sweep_y_q;
    cursor_x_d  = cursor_x_q;
    cursor_y_d  = cursor_y_q;
    clr_color_d = clr_color_q;
    char_wr_d   = 1'b0;
    wr_fg_d     = wr_fg_q;
    wr_bg_d     = wr_bg_q;
    wr_code_d   = wr_code_q;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    in_ready_d  = 1'b0;
    busy_d      = 1'b1;
    line_adv    = 1'b0;

    case (state_q)
      ST_CLR_ALL: begin
        char_wr_d = 1'b1;
        wr_code_d = CODE_SPACE;
        wr_fg_d   = clr_color_q;
        wr_bg_d   = clr_color_q;
        wr_x_d    = sweep_x_q;
        wr_y_d    = sweep_y_q;
        if (sweep_x_q == LAST_X) begin
          sweep_x_d = 6'd0;
          if (sweep_y_q == LAST_Y) begin
            sweep_y_d  = 5'd0;
            state_d    = ST_IDLE;
            cursor_x_d = 6'd0;
            cursor_y_d = 5'd0;
          end else begin
            sweep_y_d = sweep_y_q + 5'd1;
          end
        end else begin
          sweep_x_d = sweep_x_q + 6'd1;
        end
      end

      ST_CLR_LINE: begin
        char_wr_d = 1'b1;
        wr_code_d = CODE_SPACE;
        wr_fg_d   = clr_color_q;
        wr_bg_d   = clr_color_q;
        wr_x_d    = sweep_x_q;
        wr_y_d    = cursor_y_q;
        if (sweep_x_q == LAST_X) begin
          sweep_x_d = 6'd0;
          state_d   = ST_IDLE;
        end else begin
          sweep_x_d = sweep_x_q + 6'd1;
        end
      end

      ST_IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (accept) begin
          if (inData >= CODE_SPACE) begin
            // Printable: the write always lands at the old cursor, even
            // when it triggers a wrap.
            char_wr_d = 1'b1;
            wr_code_d = inData;
            wr_fg_d   = fgColor;
            wr_bg_d   = bgColor;
            wr_x_d    = cursor_x_q;
            wr_y_d    = cursor_y_q;
            if (cursor_x_q == LAST_X) begin
              line_adv = 1'b1;
            end else begin
              cursor_x_d = cursor_x_q + 6'd1;
            end
          end else begin
            case (inData)
              CODE_LF: line_adv = 1'b1;
              CODE_CR: cursor_x_d = 6'd0;
              CODE_BS: begin
                // Backspace erases the cell it moves onto; at the home
                // position there is nothing to erase.
                if (cursor_x_q != 6'd0) begin
                  cursor_x_d = cursor_x_q - 6'd1;
                  char_wr_d  = 1'b1;
                  wr_x_d     = cursor_x_q - 6'd1;
                  wr_y_d     = cursor_y_q;
                end else if (cursor_y_q != 5'd0) begin
                  cursor_x_d = LAST_X;
                  cursor_y_d = cursor_y_q - 5'd1;
                  char_wr_d  = 1'b1;
                  wr_x_d     = LAST_X;
                  wr_y_d     = cursor_y_q - 5'd1;
                end
                if ((cursor_x_q != 6'd0) || (cursor_y_q != 5'd0)) begin
                  wr_code_d = CODE_SPACE;
                  wr_fg_d   = fgColor;
                  wr_bg_d   = bgColor;
                end
              end
              CODE_FF: begin
                clr_color_d = bgColor;
                state_d     = ST_CLR_ALL;
                sweep_x_d   = 6'd0;
                sweep_y_d   = 5'd0;
                cursor_x_d  = 6'd0;
                cursor_y_d  = 5'd0;
                in_ready_d  = 1'b0;
                busy_d      = 1'b1;
              end
`ifdef VGA_TEXT_CONSOLE_TAB_EN
              CODE_TAB: begin
                if (tab_x >= 7'(COLS)) begin
                  line_adv = 1'b1;
                end else begin
                  cursor_x_d = tab_x[5:0];
                end
              end
`endif
              default: ;
            endcase
          end

          // Line advance: move to the next row (wrapping) and clear it with
          // the background colour captured at this acceptance.
          if (line_adv) begin
            cursor_x_d  = 6'd0;
            cursor_y_d  = next_row;
            clr_color_d = bgColor;
            state_d     = ST_CLR_LINE;
            sweep_x_d   = 6'd0;
            in_ready_d  = 1'b0;
            busy_d      = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_CLR_ALL;
        sweep_x_d = 6'd0;
        sweep_y_d = 5'd0;
      end
    endcase
  end

  // State and output registers. Reset restarts the full-screen clear from
  // cell (0,0) with colour 0, abandoning whatever was in flight.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CLR_ALL;
      sweep_x_q   <= 6'd0;
      sweep_y_q   <= 5'd0;
      cursor_x_q  <= 6'd0;
      cursor_y_q  <= 5'd0;
      clr_color_q <= 24'd0;
      char_wr_q   <= 1'b0;
      wr_fg_q     <= 24'd0;
      wr_bg_q     <= 24'd0;
      wr_code_q   <= 8'd0;
      wr_x_q      <= 6'd0;
      wr_y_q      <= 5'd0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      sweep_x_q   <= sweep_x_d;
      sweep_y_q   <= sweep_y_d;
      cursor_x_q  <= cursor_x_d;
      cursor_y_q  <= cursor_y_d;
      clr_color_q <= clr_color_d;
      char_wr_q   <= char_wr_d;
      wr_fg_q     <= wr_fg_d;
      wr_bg_q     <= wr_bg_d;
      wr_code_q   <= wr_code_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign inReady       = in_ready_q;
  assign busy          = busy_q;
  assign charWr        = char_wr_q;
  assign charWrFgColor = wr_fg_q;
  assign charWrBgColor = wr_bg_q;
  assign charWrCode    = wr_code_q;
  assign charWrX       = wr_x_q;
  assign charWrY       = wr_y_q;
  assign cursorX       = cursor_x_q;
  assign cursorY       = cursor_y_q;

endmodule
